// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-lite RAM slave.
// Holds the response codes, FSM states, arbitration priority and the address range check.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    Idle   = 2'b00,
    RdWait = 2'b01,
    RdResp = 2'b10,
    WrResp = 2'b11
  } state_e;

  typedef enum logic {
    PrioRead  = 1'b0,
    PrioWrite = 1'b1
  } prio_e;

  // The upper bound is computed in 33 bits so that a window ending at 4 GiB
  // does not wrap to zero.
  function automatic logic addr_in_range(logic [31:0] addr, logic [31:0] base,
                                         int unsigned depth_log2);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, base};
    hi = lo + (33'd4 << depth_log2);
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

endpackage

// File: rtl/ram_1p_be.sv
// Single-port 32-bit word RAM with per-byte write enables and a registered read port.
module ram_1p_be #(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [1 << DEPTH_LOG2];

  // Read-before-write: rdata returns the old word on a write access.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_lite_ram_slave.sv
// AXI4-lite slave serving a single-port byte-writable RAM, one transaction at a time,
// with read/write priority alternating after every granted transaction.
module axi_lite_ram_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_awaddr,
  input  logic [2:0]  axi_awprot,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [1:0]  axi_bresp,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [31:0] axi_araddr,
  input  logic [2:0]  axi_arprot,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp
);

  state_e state_q, state_d;
  prio_e  prio_q, prio_d;

  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_err_q, rd_err_d;

  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [31:0]           ram_rdata;

  logic [31:0]           aw_off, ar_off;
  logic [DEPTH_LOG2-1:0] aw_idx, ar_idx;
  logic                  aw_in_range, ar_in_range;
  logic                  ar_grant, wr_grant;

  assign aw_off      = axi_awaddr - BASE_ADDR;
  assign ar_off      = axi_araddr - BASE_ADDR;
  assign aw_idx      = aw_off[DEPTH_LOG2+1:2];
  assign ar_idx      = ar_off[DEPTH_LOG2+1:2];
  assign aw_in_range = addr_in_range(axi_awaddr, BASE_ADDR, DEPTH_LOG2);
  assign ar_in_range = addr_in_range(axi_araddr, BASE_ADDR, DEPTH_LOG2);

  logic unused;
  assign unused = ^{axi_awprot, axi_arprot, aw_off[31:DEPTH_LOG2+2], aw_off[1:0],
                    ar_off[31:DEPTH_LOG2+2], ar_off[1:0]};

  // AW and W are only ever taken together; a read wins unless a full write is
  // pending and it is the write's turn.
  assign ar_grant = (state_q == Idle) && axi_arvalid &&
                    ((prio_q == PrioRead) || !(axi_awvalid && axi_wvalid));
  assign wr_grant = (state_q == Idle) && axi_awvalid && axi_wvalid && !ar_grant;

  assign axi_arready = ar_grant;
  assign axi_awready = wr_grant;
  assign axi_wready  = wr_grant;
  assign axi_bvalid  = (state_q == WrResp);
  assign axi_rvalid  = (state_q == RdResp);
  assign axi_bresp   = bresp_q;
  assign axi_rresp   = rresp_q;
  assign axi_rdata   = rdata_q;

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    bresp_d  = bresp_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    rd_err_d = rd_err_q;
    ram_en   = 1'b0;
    ram_we   = 4'b0000;
    ram_addr = ar_idx;

    unique case (state_q)
      Idle: begin
        if (ar_grant) begin
          ram_en   = 1'b1;
          ram_addr = ar_idx;
          rd_err_d = !ar_in_range;
          prio_d   = PrioWrite;
          state_d  = RdWait;
        end else if (wr_grant) begin
          ram_en   = 1'b1;
          ram_addr = aw_idx;
          ram_we   = aw_in_range ? axi_wstrb : 4'b0000;
          bresp_d  = aw_in_range ? RESP_OKAY : RESP_SLVERR;
          prio_d   = PrioRead;
          state_d  = WrResp;
        end
      end
      RdWait: begin
        rdata_d = rd_err_q ? 32'h0 : ram_rdata;
        rresp_d = rd_err_q ? RESP_SLVERR : RESP_OKAY;
        state_d = RdResp;
      end
      RdResp: begin
        if (axi_rready) state_d = Idle;
      end
      WrResp: begin
        if (axi_bready) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= Idle;
      prio_q   <= PrioRead;
      bresp_q  <= 2'b00;
      rresp_q  <= 2'b00;
      rdata_q  <= 32'h0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      rd_err_q <= rd_err_d;
    end
  end

  ram_1p_be #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(axi_wdata),
    .rdata(ram_rdata)
  );

endmodule
